// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot decoder: FSM state encoding and
// a polarity-aware one-hot encoder.
package decoder_pkg;

    localparam int ONEHOT_MAX = 256;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_DIR = 2'd1,
        ST_SCN = 2'd2
    } state_t;

    // Out-of-range idx yields the inactive pattern, so callers can use it for range errors too.
    function automatic logic [ONEHOT_MAX-1:0] onehot_encode(
        input logic [7:0]  idx,
        input int unsigned n,
        input logic        active_low
    );
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if ({24'b0, idx} < n) begin
            v[idx] = 1'b1;
        end
        if (active_low) begin
            v = ~v;
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running prescaler for the scan walk: counts 0..PRESCALE-1 while run is
// high and flags the last count; clears to 0 whenever run is low.
module scan_prescaler #(
    parameter int PRESCALE = 4,
    parameter int PRE_W    = $clog2(PRESCALE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    always_comb begin
        tick  = run && (cnt_q == LAST);
        cnt_d = '0;
        if (run && !tick) begin
            cnt_d = cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_onehot_scan.sv
// Registered N-to-M one-hot decoder with programmable polarity; DIRECT mode
// decodes sel_in, SCAN mode walks the outputs under a prescaled index.
module decoder_onehot_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int OUT_N      = 4,
    parameter int ACTIVE_LOW = 0,
    parameter int PRESCALE   = 4,
    parameter int PRE_W      = $clog2(PRESCALE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_in,
    output logic [OUT_N-1:0] y,
    output logic [SEL_W-1:0] sel_out,
    output logic             range_err,
    output logic             wrap
);

    localparam logic [OUT_N-1:0] INACT    = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);
    localparam logic [SEL_W:0]   OUT_N_W  = (SEL_W + 1)'(OUT_N);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [OUT_N-1:0] y_q, y_d;
    logic [SEL_W-1:0] sel_out_q, sel_out_d;
    logic             range_err_q, range_err_d;
    logic             wrap_q, wrap_d;

    logic             scan_run;
    logic             tick;
    logic [SEL_W-1:0] idx_adv;

    // Prescaler only runs while already in SCN; the entry cycle restarts it at 0.
    assign scan_run = enable && mode && (state_q == ST_SCN);

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (scan_run),
        .tick (tick)
    );

    always_comb begin
        state_d     = !enable ? ST_OFF : (mode ? ST_SCN : ST_DIR);
        idx_adv     = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
        idx_d       = '0;
        y_d         = INACT;
        sel_out_d   = '0;
        range_err_d = 1'b0;
        wrap_d      = 1'b0;

        case (state_d)
            ST_DIR: begin
                if ({1'b0, sel_in} < OUT_N_W) begin
                    y_d       = OUT_N'(onehot_encode(8'(sel_in), OUT_N, ACTIVE_LOW != 0));
                    sel_out_d = sel_in;
                end else begin
                    range_err_d = 1'b1;
                end
            end
            ST_SCN: begin
                if (scan_run) begin
                    idx_d  = tick ? idx_adv : idx_q;
                    wrap_d = tick && (idx_q == LAST_IDX);
                end
                y_d       = OUT_N'(onehot_encode(8'(idx_d), OUT_N, ACTIVE_LOW != 0));
                sel_out_d = idx_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            y_q         <= INACT;
            sel_out_q   <= '0;
            range_err_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            y_q         <= y_d;
            sel_out_q   <= sel_out_d;
            range_err_q <= range_err_d;
            wrap_q      <= wrap_d;
        end
    end

    assign y         = y_q;
    assign sel_out   = sel_out_q;
    assign range_err = range_err_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_onehot_scan.sv
// Randomized and directed bench for decoder_onehot_scan across three parameter
// sets, checked against a time-based reference model.
module tb_decoder_onehot_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       mode;
    logic [2:0] sel;

    always #5 clk = ~clk;

    logic [3:0] y0;  logic [1:0] so0; logic re0, wr0;
    logic [5:0] y1;  logic [2:0] so1; logic re1, wr1;
    logic [2:0] y2;  logic [1:0] so2; logic re2, wr2;

    decoder_onehot_scan #(.SEL_W(2), .OUT_N(4), .ACTIVE_LOW(0), .PRESCALE(4)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel_in(sel[1:0]),
        .y(y0), .sel_out(so0), .range_err(re0), .wrap(wr0));

    decoder_onehot_scan #(.SEL_W(3), .OUT_N(6), .ACTIVE_LOW(1), .PRESCALE(4)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel_in(sel),
        .y(y1), .sel_out(so1), .range_err(re1), .wrap(wr1));

    decoder_onehot_scan #(.SEL_W(2), .OUT_N(3), .ACTIVE_LOW(0), .PRESCALE(1)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel_in(sel[1:0]),
        .y(y2), .sel_out(so2), .range_err(re2), .wrap(wr2));

    logic [15:0] got_y   [3];
    logic [2:0]  got_sel [3];
    logic        got_re  [3];
    logic        got_wr  [3];

    assign got_y[0] = 16'(y0);  assign got_sel[0] = 3'(so0); assign got_re[0] = re0; assign got_wr[0] = wr0;
    assign got_y[1] = 16'(y1);  assign got_sel[1] = so1;     assign got_re[1] = re1; assign got_wr[1] = wr1;
    assign got_y[2] = 16'(y2);  assign got_sel[2] = 3'(so2); assign got_re[2] = re2; assign got_wr[2] = wr2;

    int SW [3] = '{2, 3, 2};
    int NO [3] = '{4, 6, 3};
    int AL [3] = '{0, 1, 0};
    int PS [3] = '{4, 4, 1};

    // Model state: t = cycles since scan entry, -1 when not scanning.
    int          t    [3];
    logic [15:0] ey   [3];
    int          esel [3];
    bit          ere  [3];
    bit          ewr  [3];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] inact(input int i);
        return (AL[i] != 0) ? 16'((1 << NO[i]) - 1) : 16'd0;
    endfunction

    function automatic logic [15:0] pattern(input int i, input int idx);
        int v;
        v = 1 << idx;
        if (AL[i] != 0) v = ~v & ((1 << NO[i]) - 1);
        return 16'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            t[i] = -1; ey[i] = inact(i); esel[i] = 0; ere[i] = 0; ewr[i] = 0;
        end
    endtask

    task automatic model_update(input int i, input logic e, input logic m, input logic [2:0] s);
        int sv, idx;
        sv      = int'(s) & ((1 << SW[i]) - 1);
        ey[i]   = inact(i);
        esel[i] = 0;
        ere[i]  = 0;
        ewr[i]  = 0;
        if (!e) begin
            t[i] = -1;
        end else if (!m) begin
            t[i] = -1;
            if (sv < NO[i]) begin
                ey[i] = pattern(i, sv); esel[i] = sv;
            end else begin
                ere[i] = 1;
            end
        end else begin
            t[i]    = (t[i] < 0) ? 0 : t[i] + 1;
            idx     = (t[i] / PS[i]) % NO[i];
            ey[i]   = pattern(i, idx);
            esel[i] = idx;
            ewr[i]  = (t[i] > 0) && (t[i] % (PS[i] * NO[i]) == 0);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("y[%0d]", i),         32'(got_y[i]),   32'(ey[i]));
            check($sformatf("sel_out[%0d]", i),   32'(got_sel[i]), 32'(esel[i]));
            check($sformatf("range_err[%0d]", i), 32'(got_re[i]),  32'(ere[i]));
            check($sformatf("wrap[%0d]", i),      32'(got_wr[i]),  32'(ewr[i]));
        end
    endtask

    task automatic step(input logic e, input logic m, input logic [2:0] s);
        enable = e; mode = m; sel = s;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) model_update(i, e, m, s);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; sel = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 3'(k));
        step(1'b1, 1'b0, 3'd5);
        step(1'b1, 1'b0, 3'd6);

        step(1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 3'd0);

        step(1'b0, 1'b1, 3'd0);
        for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 3'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 3'd0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 3'd0);

        step(1'b1, 1'b0, 3'd2);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 3'd0);

        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 3'd0);

        begin
            logic e, m;
            e = 1'b1; m = 1'b1;
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 15) == 0) m = ~m;
                e = ($urandom_range(0, 9) != 0);
                step(e, m, 3'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder_onehot_scan.md
Name: decoder_onehot_scan

Overview:
- Registered, parametrised N-to-M one-hot decoder with programmable output polarity and two modes: DIRECT (decodes an external select) and SCAN (an internal prescaled counter walks the outputs in sequence).
- Drives multiplexed displays and row/column strobes: digit enables for 7-segment banks and keypad row drive.
- Succeeds the combinational 2-to-4 active-high decoder, adding width, polarity, range checking and autonomous scanning.

Parameters:
- SEL_W, 2, select width in bits (1..8).
- OUT_N, 4, number of decoded outputs, 2..2**SEL_W.
- ACTIVE_LOW, 0, output polarity: 0 means the asserted bit is 1; 1 means the asserted bit is 0 and all other bits are 1.
- PRESCALE, 4, clock cycles per scan step (>=1).
- PRE_W, $clog2(PRESCALE+1), prescaler counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  1 drives outputs; 0 forces all outputs inactive.
- mode  in  1  0=DIRECT, 1=SCAN.
- sel_in  in  SEL_W  select used in DIRECT mode.
- y  out  OUT_N  registered one-hot decode, polarity per ACTIVE_LOW.
- sel_out  out  SEL_W  index currently asserted on y (0 when y is inactive).
- range_err  out  1  registered; 1 while DIRECT and enable and sel_in>=OUT_N.
- wrap  out  1  single-cycle pulse on the SCAN step from OUT_N-1 to 0.

Behaviour:
- INACT = all zeros if ACTIVE_LOW=0, all ones if ACTIVE_LOW=1. Bit k asserted = bit k is the complement of INACT.
- Reset (async, any time, mid-scan included): y=INACT, sel_out=0, range_err=0, wrap=0, scan index=0, prescaler=0, state=OFF.
- Three-state machine, evaluated each clk:
  - OFF: entered when enable=0.
  - DIR: entered when enable=1 and mode=0.
  - SCN: entered when enable=1 and mode=1.
- The next state is taken directly from {enable, mode}, with no hysteresis.
- OFF: next y=INACT, sel_out=0, range_err=0, wrap=0. Prescaler and scan index are cleared to 0.
- DIR:
  - Latency is one cycle: y is the registered decode of sel_in.
  - sel_in<OUT_N: bit sel_in is asserted, sel_out=sel_in, range_err=0.
  - sel_in>=OUT_N: y=INACT, sel_out=0, range_err=1.
  - Prescaler and scan index are held at 0; wrap=0.
- SCN:
  - On the first cycle after entry (from OFF or DIR), the index is 0, bit 0 is asserted and the prescaler starts at 0.
  - Each cycle the prescaler increments. When it reaches PRESCALE-1 it returns to 0 and the index advances on the next edge.
  - Each index is therefore held for exactly PRESCALE cycles.
  - Index OUT_N-1 advances to 0, not to 2**SEL_W-1. wrap=1 for exactly the cycle in which y first shows index 0 after the wrap.
  - range_err=0 throughout SCN.
  - PRESCALE=1: the index advances every cycle.
- Mode change SCN->DIR: the next cycle shows the sel_in decode. The scan index is discarded, so re-entry always restarts at 0.
- enable deasserted mid-scan: the next cycle shows y=INACT. Re-enable restarts at index 0 with a full PRESCALE dwell.
- Exactly one bit of y is asserted whenever y != INACT; there is never a multi-hot glitch, because y comes from a single register.
- Index arithmetic is SEL_W bits wide. OUT_N==2**SEL_W wraps naturally; the compare to OUT_N-1 is still used.

Decomposition:
- Shared package decoder_pkg holds:
  - the state encoding typedef (OFF, DIR, SCN);
  - the function onehot_encode(idx, n, active_low) returning the polarity-applied vector.
- Sub-module scan_prescaler (parameter PRESCALE) holds the counter and emits a tick.
- The decoder instantiates one scan_prescaler and keeps the state register and output register in the top module.

Test Plan:
- Reset, defaults, enable=1, mode=0, sel_in stepped 0,1,2,3 -> y=0001,0010,0100,1000, each one cycle after sel_in, with sel_out tracking.
- ACTIVE_LOW=1, SEL_W=3, OUT_N=6, DIRECT, sel_in=5 then 6 -> y=011111 with range_err=0, then y=111111, range_err=1, sel_out=0.
- Defaults, SCAN for 20 cycles -> bits 0,1,2,3 each asserted for 4 cycles. wrap pulses once, when y returns to 0001 at cycle 17, not before.
- SCAN, drop enable while index=2 for 3 cycles, then restore -> y=0000 during the gap, then restarts at 0001 with a full 4-cycle dwell.
- rst asserted asynchronously mid-dwell (between clock edges) in SCAN -> y=0000, sel_out=0, wrap=0 immediately. After release, the first enabled SCAN cycle shows 0001.
- PRESCALE=1, OUT_N=3, SEL_W=2, SCAN -> y cycles 001,010,100,001 every cycle. Index 3 is never reached; wrap fires every third cycle.
